// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// TX state encoding and STATUS bit positions.
package uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// UART transmitter on the data bus: TXDATA/STATUS/BAUDDIV registers, a TX FIFO
// and an 8N1 serialiser whose divisor is latched at each START.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t   r_state;
    logic [15:0] r_baud;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit;
    logic        r_ovf;
    logic        r_tx;
    logic        r_irq;

    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_off;
    logic        w_push;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [7:0]  w_fifo_data;
    logic        w_expire;
    logic        w_enter;
    logic        w_empty_next;
    tx_state_t   w_state_next;
    logic [15:0] w_div_src;
    logic [15:0] w_cnt_next;
    logic [7:0]  w_shift_next;
    logic [2:0]  w_bit_next;
    logic        w_tx_next;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_wr      = uart_sel & wr_en;
    assign w_rd      = uart_sel & rd_en;
    assign w_off     = address[3:2];
    assign w_push    = w_wr & (w_off == UART_TXDATA);
    assign w_ovf_set = w_push & w_fifo_full & ~w_pop;
    assign w_expire  = (r_cnt == 16'd0);
    assign w_unused  = ^{address[31:4], address[1:0], wdata[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Next-state logic; every state entry and every expiry reloads the baud counter.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_enter      = 1'b0;
        case (r_state)
            IDLE: if (!w_fifo_empty) begin
                w_pop = 1'b1; w_enter = 1'b1; w_state_next = START;
            end
            START: if (w_expire) begin
                w_enter = 1'b1; w_state_next = DATA;
            end
            DATA: if (w_expire && r_bit == 3'd7) begin
                w_enter = 1'b1; w_state_next = STOP;
            end
            STOP: if (w_expire) begin
                w_enter = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop = 1'b1; w_state_next = START;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_div_src    = w_pop ? r_baud : r_div;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        if (w_enter || w_expire) w_cnt_next = w_div_src - 16'd1;
        else                     w_cnt_next = r_cnt - 16'd1;
        if (w_pop) begin
            w_shift_next = w_fifo_data;
            w_bit_next   = 3'd0;
        end else if (r_state == DATA && w_expire && r_bit != 3'd7) begin
            w_shift_next = {1'b0, r_shift[7:1]};
            w_bit_next   = r_bit + 3'd1;
        end

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase

        w_empty_next = ((w_fifo_count == CW'(0)) && !w_push) ||
                       ((w_fifo_count == CW'(1)) && w_pop && !w_push);
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_irq   <= 1'b1;
            r_div   <= 16'(BAUD_DIV);
            r_cnt   <= 16'd0;
            r_shift <= 8'd0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_irq   <= w_empty_next && (w_state_next == IDLE);
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            if (w_pop) r_div <= r_baud;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud <= 16'(BAUD_DIV);
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr && w_off == UART_BAUD)
                r_baud <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_wr && w_off == UART_STATUS && wdata[ST_OVF])
                r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status                      = 32'd0;
        w_status[ST_BUSY]             = (r_state != IDLE);
        w_status[ST_FULL]             = w_fifo_full;
        w_status[ST_EMPTY]            = w_fifo_empty;
        w_status[ST_OVF]              = r_ovf;
        w_status[ST_CNT_HI:ST_CNT_LO] = 5'(w_fifo_count);
        rdata = 32'd0;
        if (w_rd) begin
            case (w_off)
                UART_STATUS: rdata = w_status;
                UART_BAUD:   rdata = {16'd0, r_baud};
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign tx     = r_tx;
    assign tx_irq = r_irq;

endmodule
